// File: rtl/aeolus_pkg.sv
// aeolus_pkg: shared types and constants for the Aeolus sequencer.
// Provides the state encoding, the width of the retired counter and the default ROM address width.
package aeolus_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;
    localparam int RETIRED_WIDTH = 8;
    localparam int DEFAULT_ROM_ADDRESS_WIDTH = 5;
endpackage

// File: rtl/aeolus_sequencer_if.sv
// aeolus_sequencer_if: control and status bundle between the board controls and the sequencer.
// Controls (master to slave): run, step, clear.
// Status (slave to master): pc, exec_en, state, halted, retired.
interface aeolus_sequencer_if #(parameter int AW = aeolus_pkg::DEFAULT_ROM_ADDRESS_WIDTH);
    import aeolus_pkg::*;
    logic                     run;
    logic                     step;
    logic                     clear;
    logic [AW-1:0]            pc;
    logic                     exec_en;
    state_t                   state;
    logic                     halted;
    logic [RETIRED_WIDTH-1:0] retired;
    modport master (output run, step, clear, input pc, exec_en, state, halted, retired);
    modport slave  (input run, step, clear, output pc, exec_en, state, halted, retired);
endinterface

// File: rtl/aeolus_sequencer_tick_prescaler.sv
// tick_prescaler: counter that pulses tc when it reaches TARGET while enabled, then reloads 0.
// Ports: clk, reset (async active-low), clr (sync clear, wins over en), en (count enable), tc (terminal count).
module tick_prescaler #(
    parameter int TARGET = 24,
    localparam int W = TARGET > 0 ? $clog2(TARGET + 1) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [W-1:0] count;
    assign tc = en && count == W'(TARGET);
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= tc ? '0 : count + W'(1);
endmodule

// File: rtl/aeolus_sequencer.sv
// aeolus_sequencer: run/step/halt controller that owns the program address and issues exec_en.
// Ports: clk, reset (async active-low), sif (slave: run/step/clear in; pc/exec_en/state/halted/retired out).
module aeolus_sequencer
    import aeolus_pkg::*;
#(
    parameter int ROM_ADDRESS_WIDTH = DEFAULT_ROM_ADDRESS_WIDTH,
    parameter int PROGRAM_LENGTH    = 32,
    parameter int DIV_TARGET        = 24,
    parameter int LOOP              = 0
) (
    input logic clk,
    input logic reset,
    aeolus_sequencer_if.slave sif
);
    localparam logic [ROM_ADDRESS_WIDTH-1:0] LAST_PC = ROM_ADDRESS_WIDTH'(PROGRAM_LENGTH - 1);
    state_t                       state;
    logic [ROM_ADDRESS_WIDTH-1:0] pc;
    logic                         exec_en;
    logic                         halted;
    logic                         step_q;
    logic [RETIRED_WIDTH-1:0]     retired;
    logic                         running;
    logic                         step_edge;
    logic                         at_last;
    logic                         tick;
    // The prescaler only counts while run is held in RUN; any other cycle parks it at 0.
    assign running   = state == RUN && sif.run;
    assign step_edge = sif.step && !step_q;
    assign at_last   = pc == LAST_PC;
    tick_prescaler #(.TARGET(DIV_TARGET)) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (sif.clear || !running),
        .en   (running),
        .tc   (tick)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            pc      <= '0;
            exec_en <= 1'b0;
            halted  <= 1'b0;
            retired <= '0;
            step_q  <= 1'b0;
        end else begin
            step_q <= sif.step;
            if (sif.clear) begin
                state   <= IDLE;
                pc      <= '0;
                exec_en <= 1'b0;
                halted  <= 1'b0;
                retired <= '0;
            end else begin
                exec_en <= 1'b0;
                // Retire the instruction whose exec_en cycle is ending.
                if (exec_en) begin
                    retired <= &retired ? retired : retired + 1'b1;
                    pc      <= !at_last ? pc + 1'b1 : (LOOP != 0 ? '0 : pc);
                end
                // Reaching the end of a non-looping program overrides every other transition.
                if (exec_en && at_last && LOOP == 0) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end else begin
                    case (state)
                        IDLE:
                            if (sif.run)
                                state <= RUN;
                            else if (step_edge) begin
                                state   <= STEP;
                                exec_en <= 1'b1;
                            end
                        RUN:
                            if (!sif.run)
                                state <= IDLE;
                            else if (tick)
                                exec_en <= 1'b1;
                        STEP:    state <= IDLE;
                        default: state <= state;
                    endcase
                end
            end
        end
    assign sif.pc      = pc;
    assign sif.exec_en = exec_en;
    assign sif.state   = state;
    assign sif.halted  = halted;
    assign sif.retired = retired;
endmodule
